flop_fifo: RTL and testbench

Synchronous first-in/first-out buffer built from a flip-flop register array, with push/pop handshake and full/empty status flags. It decouples a producer and a consumer that share one clock domain. It is a generic leaf block, instantiated wherever a small, shallow, parameterizable queue is needed.

---
 rtl/flop_fifo.sv | 64 ++++++
 tb/tb_flop_fifo.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/flop_fifo.sv
// Shallow single-clock FIFO built from a flip-flop register array.
// Push/pop handshake with full/empty decoded from the occupancy count.
module flop_fifo #(
  parameter int depth = 16,
  parameter int bits  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [bits-1:0] Din,
  output logic            full,
  output logic            empty,
  output logic [bits-1:0] Dout
);

  localparam int pw = (depth > 1) ? $clog2(depth) : 1;
  localparam int cw = $clog2(depth + 1);

  logic [bits-1:0] mem [depth];
  logic [pw-1:0]   wptr;
  logic [pw-1:0]   rptr;
  logic [cw-1:0]   count;
  logic            doRead;
  logic            doWrite;
  logic [pw-1:0]   wptrNext;
  logic [pw-1:0]   rptrNext;

  assign full  = (count == cw'(depth));
  assign empty = (count == '0);

  // A pop frees a slot, so a push into a full FIFO is accepted if a pop accompanies it.
  assign doRead  = pop & ~empty;
  assign doWrite = push & (~full | doRead);

  assign wptrNext = (wptr == pw'(depth - 1)) ? '0 : wptr + pw'(1);
  assign rptrNext = (rptr == pw'(depth - 1)) ? '0 : rptr + pw'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      Dout  <= '0;
    end else begin
      if (doWrite) wptr <= wptrNext;
      if (doRead) begin
        rptr <= rptrNext;
        Dout <= mem[rptr];
      end
      case ({doWrite, doRead})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left uncleared on reset.
  always_ff @(posedge clk) begin
    if (rst && doWrite) mem[wptr] <= Din;
  end

endmodule

// File: tb/tb_flop_fifo.sv
// Scoreboard bench for flop_fifo: stimulus pushes expected post-edge state,
// a monitor pops and compares one cycle later against a queue-based model.
module tb_flop_fifo;

  localparam int depth = 16;
  localparam int bits  = 8;

  logic            clk;
  logic            rst;
  logic            push;
  logic            pop;
  logic [bits-1:0] Din;
  logic            full;
  logic            empty;
  logic [bits-1:0] Dout;

  typedef struct {
    int            cnt;
    bit            f;
    bit            e;
    logic [bits-1:0] d;
    string         tag;
  } exp_t;

  exp_t            expQ[$];
  logic [bits-1:0] modelQ[$];
  logic [bits-1:0] modelDout;
  int              checks;
  int              failures;
  bit              stimDone;

  flop_fifo #(.depth(depth), .bits(bits)) dut (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .Din  (Din),
    .full (full),
    .empty(empty),
    .Dout (Dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs and record what the FIFO must look like after that edge.
  task automatic applyStimulus(input bit r, input bit p, input bit q,
                               input logic [bits-1:0] d, input string tag);
    exp_t e;
    bit   canRead;
    bit   canWrite;
    @(negedge clk);
    rst  = r;
    push = p;
    pop  = q;
    Din  = d;
    if (!r) begin
      modelQ.delete();
      modelDout = '0;
    end else begin
      canRead  = q && (modelQ.size() > 0);
      canWrite = p && ((modelQ.size() < depth) || canRead);
      if (canRead) modelDout = modelQ.pop_front();
      if (canWrite) modelQ.push_back(d);
    end
    e.cnt = modelQ.size();
    e.f   = (modelQ.size() == depth);
    e.e   = (modelQ.size() == 0);
    e.d   = modelDout;
    e.tag = tag;
    expQ.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.tag, ".count"}, 32'(dut.count), 32'(e.cnt));
        checkOutput({e.tag, ".full"},  32'(full),      32'(e.f));
        checkOutput({e.tag, ".empty"}, 32'(empty),     32'(e.e));
        checkOutput({e.tag, ".Dout"},  32'(Dout),      32'(e.d));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int cyc;
    rst = 1'b0; push = 1'b0; pop = 1'b0; Din = '0;
    modelDout = '0;
    checks = 0; failures = 0; stimDone = 0;

    applyStimulus(0, 0, 0, 8'h00, "reset");
    applyStimulus(1, 0, 0, 8'h00, "resetRelease");

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 0, 8'(i), "partialPush");
      applyStimulus(1, 0, 0, 8'hFF, "partialIdle");
    end

    for (int i = 8; i < 16; i++) applyStimulus(1, 1, 0, 8'(i), "fill");
    applyStimulus(1, 1, 0, 8'd16, "overflow");

    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 1, 8'h00, "drain");
    applyStimulus(1, 0, 1, 8'h00, "popEmpty");
    applyStimulus(1, 1, 1, 8'h77, "pushPopEmpty");
    applyStimulus(1, 0, 1, 8'h00, "pushPopEmptyDrain");

    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 8'(i), "midFill");
    applyStimulus(1, 1, 1, 8'd4, "midPushPop");
    for (int i = 5; i < 17; i++) applyStimulus(1, 1, 0, 8'(i), "toFull");
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 1, 8'(8'h40 + i), "fullPushPop");
    for (int i = 0; i < 11; i++) applyStimulus(1, 0, 1, 8'h00, "partDrain");

    applyStimulus(0, 1, 1, 8'h33, "midReset");
    applyStimulus(1, 1, 0, 8'hA5, "postResetPush");
    applyStimulus(1, 0, 1, 8'h00, "postResetPop");

    for (cyc = 0; cyc < 3000; cyc++) begin
      applyStimulus(($urandom_range(0, 199) != 0), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) == 0 ? 1'b1 : ($urandom_range(0, 1) == 1),
                    8'($urandom), "random");
    end

    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
